// File: rtl/mul_div_unit_if.sv
// mul_div_unit_if: request/result bundle between the control decoder and mul_div_unit.
interface mul_div_unit_if #(parameter int WIDTH = 16);
   logic             start;
   logic [1:0]       multiDiv;
   logic [WIDTH-1:0] opA;
   logic [WIDTH-1:0] opB;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] resultLo;
   logic [WIDTH-1:0] resultHi;
   logic             divByZero;

   modport master (
      output start, multiDiv, opA, opB,
      input  busy, done, resultLo, resultHi, divByZero
   );

   modport slave (
      input  start, multiDiv, opA, opB,
      output busy, done, resultLo, resultHi, divByZero
   );
endinterface

// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative shift-add multiply / restoring divide, one bit per cycle.
// Define MULDIV_SIGNED_EN for two's complement operands (magnitudes in, sign fix in FIX).
module mul_div_unit #(
   parameter int WIDTH = 16
) (
   input  logic          clk,
   input  logic          rst,
   mul_div_unit_if.slave bus
);
   // state | meaning
   // IDLE  | waiting for start with multiDiv 01/10
   // MUL   | one multiplier bit per cycle, LSB first
   // DIV   | one quotient bit per cycle, MSB first; zero divisor exits at once
   // FIX   | sign correction, register results, pulse done
   typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;

   state_t             state, state_nxt;
   logic [4:0]         cnt;
   logic [2*WIDTH-1:0] acc;
   logic [WIDTH-1:0]   quo, rem, mag_a, mag_b;
   logic [WIDTH-1:0]   mag_a_in, mag_b_in;
   logic [WIDTH-1:0]   fix_lo, fix_hi, res_lo, res_hi;
   logic [WIDTH:0]     mul_sum, div_trial, div_diff;
   logic               is_div, dbz, dbz_out, done_r, busy_c;
   logic               accept, last_iter;

   assign accept    = (state == S_IDLE) && bus.start &&
                      ((bus.multiDiv == 2'b01) || (bus.multiDiv == 2'b10));
   assign last_iter = (cnt == 5'(WIDTH - 1));

`ifdef MULDIV_SIGNED_EN
   logic sign_a, sign_b;

   always_comb begin
      mag_a_in = bus.opA[WIDTH-1] ? -bus.opA : bus.opA;
      mag_b_in = bus.opB[WIDTH-1] ? -bus.opB : bus.opB;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sign_a <= 1'b0;
         sign_b <= 1'b0;
      end else if (accept) begin
         sign_a <= bus.opA[WIDTH-1];
         sign_b <= bus.opB[WIDTH-1];
      end
   end
`else
   always_comb begin
      mag_a_in = bus.opA;
      mag_b_in = bus.opB;
   end
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: if (accept) state_nxt = (bus.multiDiv == 2'b01) ? S_MUL : S_DIV;
         S_MUL:  if (last_iter) state_nxt = S_FIX;
         S_DIV:  if (last_iter || (mag_b == '0)) state_nxt = S_FIX;
         S_FIX:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      busy_c = (state != S_IDLE);
   end

   // Upper half of acc accumulates; the multiplier shifts out of the lower half.
   assign mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? mag_a : '0)};
   assign div_trial = {rem, quo[WIDTH-1]};
   assign div_diff  = div_trial - {1'b0, mag_b};

   always_comb begin
      fix_lo = is_div ? quo : acc[WIDTH-1:0];
      fix_hi = is_div ? rem : acc[2*WIDTH-1:WIDTH];
`ifdef MULDIV_SIGNED_EN
      if (!is_div && (sign_a ^ sign_b)) {fix_hi, fix_lo} = -acc;
      if (is_div && (sign_a ^ sign_b))  fix_lo = -quo;
      if (is_div && sign_a)             fix_hi = -rem;
      // quo still holds |opA| here, so re-negating recovers the raw dividend
      if (dbz) begin
         fix_lo = '1;
         fix_hi = sign_a ? -quo : quo;
      end
`else
      if (dbz) begin
         fix_lo = '1;
         fix_hi = quo;
      end
`endif
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt     <= '0;
         acc     <= '0;
         quo     <= '0;
         rem     <= '0;
         mag_a   <= '0;
         mag_b   <= '0;
         is_div  <= 1'b0;
         dbz     <= 1'b0;
         dbz_out <= 1'b0;
         res_lo  <= '0;
         res_hi  <= '0;
         done_r  <= 1'b0;
      end else begin
         done_r <= (state == S_FIX);
         case (state)
            S_IDLE: if (accept) begin
               mag_a  <= mag_a_in;
               mag_b  <= mag_b_in;
               is_div <= (bus.multiDiv == 2'b10);
               cnt    <= '0;
               acc    <= {{WIDTH{1'b0}}, mag_b_in};
               quo    <= mag_a_in;
               rem    <= '0;
               dbz    <= 1'b0;
            end
            S_MUL: begin
               acc <= {mul_sum, acc[WIDTH-1:1]};
               cnt <= cnt + 5'd1;
            end
            S_DIV: begin
               if (mag_b == '0) begin
                  dbz <= 1'b1;
               end else begin
                  rem <= div_diff[WIDTH] ? div_trial[WIDTH-1:0] : div_diff[WIDTH-1:0];
                  quo <= {quo[WIDTH-2:0], ~div_diff[WIDTH]};
                  cnt <= cnt + 5'd1;
               end
            end
            S_FIX: begin
               res_lo  <= fix_lo;
               res_hi  <= fix_hi;
               dbz_out <= dbz;
            end
            default: ;
         endcase
      end
   end

   assign bus.busy      = busy_c;
   assign bus.done      = done_r;
   assign bus.resultLo  = res_lo;
   assign bus.resultHi  = res_hi;
   assign bus.divByZero = dbz_out;
endmodule
